// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM,
// and registered press/release/long-press strobes plus a run/stop toggle.
// Timing from a stable key_n edge to the matching strobe is
// 2 (sync) + DEBOUNCE_CYCLES + 1 clocks. DEBOUNCE_CYCLES is expected to be >= 2.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int MAX_CYC     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYC) + 1;
  // The IDLE/HELD cycle that opens a wait state is the first stable sample,
  // so the wait state itself needs DEBOUNCE_CYCLES-1 more; it exits on the
  // cycle the counter shows DEBOUNCE_CYCLES-2.
  localparam int DB_LAST_I   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam int LONG_LAST_I = (LONG_CYCLES > 1) ? LONG_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_LAST_I);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             ks_meta;
  logic             ks;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_cnt_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             long_fired;
  logic             press_ev;
  logic             rel_ev;
  logic             long_ev;
  logic             press_p0;
  logic             rel_p0;

  // Two-flop synchronizer; idles high so a released key reads as stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_meta <= 1'b1;
      ks      <= 1'b1;
    end else begin
      ks_meta <= key_n;
      ks      <= ks_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state: any sample disagreeing with a wait state aborts it
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (!ks) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (ks)                     state_d = IDLE;
        else if (db_cnt == DB_LAST) state_d = HELD;
      end
      HELD: begin
        if (ks) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!ks)                    state_d = HELD;
        else if (db_cnt == DB_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counter updates and strobe requests
  always_comb begin
    db_cnt_d   = '0;
    hold_cnt_d = hold_cnt;
    press_ev   = 1'b0;
    rel_ev     = 1'b0;
    long_ev    = 1'b0;

    // Debounce count only survives while a wait state keeps seeing its level;
    // any other path clears it, so a bounce never leaves partial credit.
    case (state)
      PRESS_WAIT:   if (!ks) db_cnt_d = db_cnt + CNT_ONE;
      RELEASE_WAIT: if (ks)  db_cnt_d = db_cnt + CNT_ONE;
      default:      db_cnt_d = '0;
    endcase

    press_ev = (state == PRESS_WAIT)   && (state_d == HELD);
    rel_ev   = (state == RELEASE_WAIT) && (state_d == IDLE);

    // Hold time runs through release bounces and saturates instead of wrapping
    if (press_p0) begin
      hold_cnt_d = '0;
    end else if (((state == HELD) || (state == RELEASE_WAIT)) && (hold_cnt != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt + CNT_ONE;
    end

    // The press cycle still carries the previous press's stale hold count,
    // so it is excluded; that also keeps long and press strobes apart.
    long_ev = ((state == HELD) || (state == RELEASE_WAIT)) &&
              (hold_cnt == LONG_LAST) && !long_fired && !press_p0;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      db_cnt   <= db_cnt_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  // Accepted-edge events are held one cycle so the strobes land on the edge after entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_p0 <= 1'b0;
      rel_p0   <= 1'b0;
    end else begin
      press_p0 <= press_ev;
      rel_p0   <= rel_ev;
    end
  end

  // Registered level, strobes, run/stop toggle and once-per-press long flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
      long_fired    <= 1'b0;
    end else begin
      press_pulse   <= press_p0;
      release_pulse <= rel_p0;
      long_pulse    <= long_ev;
      if (press_p0) begin
        key_state  <= 1'b1;
        toggle     <= ~toggle;
        long_fired <= 1'b0;
      end else if (long_ev) begin
        long_fired <= 1'b1;
      end
      if (rel_p0) begin
        key_state <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable samples needed to accept a press or release (20 ms at 50 MHz).
REQ-002 The module SHALL have parameter LONG_CYCLES, default 50000000, giving the number of cycles a key must be held, counted from press acceptance, to flag a long press (1 s at 50 MHz).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port key_n, input, 1 bit: raw push-button, active-low (0 = pressed), asynchronous to clk.
REQ-006 The module SHALL have port key_state, output, 1 bit: debounced level, 1 = pressed.
REQ-007 The module SHALL have port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
REQ-008 The module SHALL have port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-009 The module SHALL have port long_pulse, output, 1 bit: one-cycle strobe when a hold reaches LONG_CYCLES.
REQ-010 The module SHALL have port toggle, output, 1 bit: run/stop flag feeding the downstream counter; flips on each accepted press.

Function
REQ-011 key_n SHALL pass through a two-flop synchronizer; both flops reset to 1; every reference to "sample" below means the synchronizer output ks.
REQ-012 The debounce counter SHALL be sized by $clog2 of the larger of the two parameters, plus 1; the hold counter SHALL saturate and never wrap.
REQ-013 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 In IDLE, ks=0 SHALL move the FSM to PRESS_WAIT with the debounce counter cleared.
REQ-015 In PRESS_WAIT, ks=1 SHALL return the FSM to IDLE with no output change (bounce rejected).
REQ-016 In PRESS_WAIT, ks=0 SHALL increment the debounce counter; when ks has been 0 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL enter HELD.
REQ-017 On entry to HELD, the next edge SHALL set key_state=1, pulse press_pulse for exactly one cycle, invert toggle, clear the hold counter, and clear the long-fired flag.
REQ-018 In HELD, the hold counter SHALL increment each cycle.
REQ-019 When the hold count reaches LONG_CYCLES-1 and the long-fired flag is clear, long_pulse SHALL assert for one cycle and the long-fired flag SHALL set; at most one long_pulse SHALL occur per press.
REQ-020 In HELD, ks=1 SHALL move the FSM to RELEASE_WAIT with the debounce counter cleared.
REQ-021 In RELEASE_WAIT, ks=0 SHALL return the FSM to HELD; the hold counter and long-fired flag SHALL be preserved, and no pulses SHALL be issued.
REQ-022 In RELEASE_WAIT, ks=1 for DEBOUNCE_CYCLES consecutive cycles SHALL move the FSM to IDLE, set key_state=0 and pulse release_pulse for one cycle.
REQ-023 The hold counter SHALL keep counting during RELEASE_WAIT.
REQ-024 press_pulse, release_pulse and long_pulse SHALL be registered outputs and SHALL never be high in the same cycle as one another.
REQ-025 Press-acceptance latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 clk cycles from a stable key_n fall to press_pulse high; release latency SHALL be symmetric.
REQ-026 A bounce that restarts a wait state SHALL fully restart the debounce count; no partial credit SHALL be carried.

Reset
REQ-027 While rst=1, state SHALL be IDLE; both counters SHALL be 0; synchronizer flops SHALL be 1; key_state, press_pulse, release_pulse, long_pulse, toggle and the long-fired flag SHALL be 0.
REQ-028 Reset asserted mid-press SHALL emit no release_pulse.
REQ-029 After reset deasserts with key_n held at 0, a full debounce SHALL run before press_pulse asserts.

Verification (bench: DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-030 Clean press: key_n 1→0 held for 30 cycles -> press_pulse exactly once, 7 cycles after the fall; key_state=1; toggle 0→1; long_pulse once, 20 cycles after press_pulse.
REQ-031 Bounce: key_n toggles 0,1,0,1 at 1-cycle intervals, then settles at 0 -> exactly one press_pulse, 7 cycles after the last fall; no release_pulse.
REQ-032 Glitch: 3-cycle low pulse on key_n from idle -> no pulses; key_state stays 0; toggle unchanged.
REQ-033 Release bounce: while held for 10 cycles, key_n 1 for 2 cycles then 0 -> no release_pulse; long_pulse still occurs exactly once at hold count 19.
REQ-034 Two full press/release cycles -> toggle sequence 0→1→0; release_pulse 7 cycles after each stable rise; pulses never overlap.
REQ-035 Reset mid-press: assert rst in HELD -> all outputs 0 asynchronously; no release_pulse; after deassert with key_n=0, press_pulse occurs 7 cycles later.
